// File: rtl/nmea_rmc_tx_pkg.sv
// Shared constants, state encodings and character helpers for the $GPRMC transmitter.
package nmea_pkg;

  localparam int SENTENCE_LEN = 35;

  localparam logic [55:0] HDR_STR     = "$GPRMC,";
  localparam logic [7:0]  ASCII_STAR  = 8'h2A;
  localparam logic [7:0]  ASCII_COMMA = 8'h2C;
  localparam logic [7:0]  ASCII_CR    = 8'h0D;
  localparam logic [7:0]  ASCII_LF    = 8'h0A;
  localparam logic [7:0]  ASCII_A     = 8'h41;
  localparam logic [7:0]  ASCII_V     = 8'h56;

  localparam logic [5:0] HDR_LAST  = 6'd6;
  localparam logic [5:0] TIME_IDX  = 6'd7;
  localparam logic [5:0] STAT_IDX  = 6'd14;
  localparam logic [5:0] DATE_IDX  = 6'd22;
  localparam logic [5:0] CSUM_END  = 6'd29;
  localparam logic [5:0] STAR_IDX  = 6'd30;
  localparam logic [5:0] CSUM_IDX  = 6'd31;
  localparam logic [5:0] LAST_IDX  = 6'(SENTENCE_LEN - 1);

  typedef enum logic [1:0] {SEQ_IDLE, SEQ_LOAD, SEQ_SEND, SEQ_DONE} seq_state_t;
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

  // Non-BCD nibbles deliberately come out as A-F so bad inputs are visible downstream.
  function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
    if (nib < 4'd10) return 8'h30 + {4'h0, nib};
    else             return 8'h37 + {4'h0, nib};
  endfunction

  function automatic logic [3:0] bcd_digit(input logic [23:0] v, input logic [5:0] pos);
    case (pos)
      6'd0:    return v[23:20];
      6'd1:    return v[19:16];
      6'd2:    return v[15:12];
      6'd3:    return v[11:8];
      6'd4:    return v[7:4];
      default: return v[3:0];
    endcase
  endfunction

endpackage

// File: rtl/nmea_rmc_tx_if.sv
// Control/status bundle between a sentence requester and the $GPRMC transmitter.
interface nmea_rmc_tx_if;
  logic [15:0] i_Clks_Per_Bit;
  logic        i_Start;
  logic [23:0] i_Time;
  logic [23:0] i_Date;
  logic        i_Valid;
  logic        o_TX_Serial;
  logic        o_Busy;
  logic        o_Done;

  modport master (
    output i_Clks_Per_Bit, i_Start, i_Time, i_Date, i_Valid,
    input  o_TX_Serial, o_Busy, o_Done
  );

  modport slave (
    input  i_Clks_Per_Bit, i_Start, i_Time, i_Date, i_Valid,
    output o_TX_Serial, o_Busy, o_Done
  );
endinterface

// File: rtl/nmea_rmc_tx_uart_tx.sv
// 8N1 UART transmitter; pairs with UART_RX. Accepts a new byte in the last stop-bit
// cycle so back-to-back bytes run without an idle gap.
module uart_tx
  import nmea_pkg::*;
(
  input  logic        i_Clock,
  input  logic        i_Reset,
  input  logic [15:0] i_Clks_Per_Bit,
  input  logic        i_TX_DV,
  input  logic [7:0]  i_TX_Byte,
  output logic        o_TX_Serial,
  output logic        o_TX_Active,
  output logic        o_TX_Done
);

  tx_state_t   state_q, state_n;
  logic [15:0] cnt_q, cnt_n;
  logic [15:0] cpb_q, cpb_n;
  logic [2:0]  bit_q, bit_n;
  logic [7:0]  sh_q, sh_n;
  logic        ser_q, ser_n;
  logic        tc;
  logic        load;

  assign tc = (cnt_q == 16'd0);

  always_comb begin
    state_n = state_q;
    cnt_n   = cnt_q;
    cpb_n   = cpb_q;
    bit_n   = bit_q;
    sh_n    = sh_q;
    ser_n   = ser_q;
    load    = 1'b0;
    case (state_q)
      TX_IDLE: begin
        if (i_TX_DV) load = 1'b1;
      end
      TX_START: begin
        if (tc) begin
          state_n = TX_DATA;
          cnt_n   = cpb_q - 16'd1;
          ser_n   = sh_q[0];
          sh_n    = {1'b0, sh_q[7:1]};
          bit_n   = 3'd0;
        end else begin
          cnt_n = cnt_q - 16'd1;
        end
      end
      TX_DATA: begin
        if (tc) begin
          cnt_n = cpb_q - 16'd1;
          if (bit_q == 3'd7) begin
            state_n = TX_STOP;
            ser_n   = 1'b1;
          end else begin
            bit_n = bit_q + 3'd1;
            ser_n = sh_q[0];
            sh_n  = {1'b0, sh_q[7:1]};
          end
        end else begin
          cnt_n = cnt_q - 16'd1;
        end
      end
      TX_STOP: begin
        if (tc) begin
          if (i_TX_DV) load = 1'b1;
          else         state_n = TX_IDLE;
        end else begin
          cnt_n = cnt_q - 16'd1;
        end
      end
      default: state_n = TX_IDLE;
    endcase
    if (load) begin
      state_n = TX_START;
      cnt_n   = i_Clks_Per_Bit - 16'd1;
      cpb_n   = i_Clks_Per_Bit;
      sh_n    = i_TX_Byte;
      ser_n   = 1'b0;
      bit_n   = 3'd0;
    end
  end

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state_q <= TX_IDLE;
      cnt_q   <= '0;
      cpb_q   <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      ser_q   <= 1'b1;
    end else begin
      state_q <= state_n;
      cnt_q   <= cnt_n;
      cpb_q   <= cpb_n;
      bit_q   <= bit_n;
      sh_q    <= sh_n;
      ser_q   <= ser_n;
    end
  end

  // Done one cycle early gives the sequencer its LOAD cycle inside the stop bit.
  assign o_TX_Done   = (state_q == TX_STOP) && (cnt_q == 16'd1);
  assign o_TX_Active = (state_q != TX_IDLE);
  assign o_TX_Serial = ser_q;

endmodule

// File: rtl/nmea_rmc_tx.sv
// $GPRMC sentence generator: latches BCD time/date/status, builds the 35-byte sentence
// with XOR checksum and streams it through uart_tx.
//
//   state | meaning
//   IDLE  | waiting; on accept latches fields and hands byte 0 ('$') to the UART
//   LOAD  | hands byte[idx] to the UART (runs during the previous byte's last stop cycle)
//   SEND  | waits for the UART's end-of-byte indication
//   DONE  | last stop cycle; o_Done fires the following cycle
module nmea_rmc_tx
  import nmea_pkg::*;
(
  input  logic i_Clock,
  input  logic i_Reset,
  nmea_rmc_tx_if.slave bus
);

  seq_state_t  state_q, state_n;
  logic [5:0]  idx_q, idx_n;
  logic [7:0]  csum_q, csum_n;
  logic [23:0] time_q, date_q;
  logic        valid_q;
  logic        done_q;
  logic        accept;
  logic        tx_dv;
  logic        tx_serial;
  logic        tx_active;
  logic        tx_done;
  logic [7:0]  byte_mux;
  logic [5:0]  dig_pos;

  assign accept = (state_q == SEQ_IDLE) && bus.i_Start && !done_q;

  always_comb begin
    byte_mux = ASCII_COMMA;
    dig_pos  = '0;
    if (idx_q <= HDR_LAST) begin
      byte_mux = HDR_STR[(6'd48 - {idx_q[2:0], 3'b000}) +: 8];
    end else if (idx_q < TIME_IDX + 6'd6) begin
      dig_pos  = idx_q - TIME_IDX;
      byte_mux = hex_ascii(bcd_digit(time_q, dig_pos));
    end else if (idx_q == STAT_IDX) begin
      byte_mux = valid_q ? ASCII_A : ASCII_V;
    end else if (idx_q >= DATE_IDX && idx_q < DATE_IDX + 6'd6) begin
      dig_pos  = idx_q - DATE_IDX;
      byte_mux = hex_ascii(bcd_digit(date_q, dig_pos));
    end else if (idx_q == STAR_IDX) begin
      byte_mux = ASCII_STAR;
    end else if (idx_q == CSUM_IDX) begin
      byte_mux = hex_ascii(csum_q[7:4]);
    end else if (idx_q == CSUM_IDX + 6'd1) begin
      byte_mux = hex_ascii(csum_q[3:0]);
    end else if (idx_q == LAST_IDX - 6'd1) begin
      byte_mux = ASCII_CR;
    end else if (idx_q == LAST_IDX) begin
      byte_mux = ASCII_LF;
    end
  end

  always_comb begin
    state_n = state_q;
    idx_n   = idx_q;
    csum_n  = csum_q;
    tx_dv   = 1'b0;
    case (state_q)
      SEQ_IDLE: begin
        if (accept) begin
          tx_dv   = 1'b1;
          state_n = SEQ_SEND;
        end
      end
      SEQ_LOAD: begin
        tx_dv   = 1'b1;
        state_n = SEQ_SEND;
        if (idx_q <= CSUM_END) csum_n = csum_q ^ byte_mux;
      end
      SEQ_SEND: begin
        if (tx_done) begin
          if (idx_q == LAST_IDX) begin
            state_n = SEQ_DONE;
          end else begin
            idx_n   = idx_q + 6'd1;
            state_n = SEQ_LOAD;
          end
        end
      end
      SEQ_DONE: begin
        state_n = SEQ_IDLE;
        idx_n   = '0;
        csum_n  = '0;
      end
      default: state_n = SEQ_IDLE;
    endcase
  end

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state_q <= SEQ_IDLE;
      idx_q   <= '0;
      csum_q  <= '0;
      time_q  <= '0;
      date_q  <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_n;
      idx_q   <= idx_n;
      csum_q  <= csum_n;
      done_q  <= (state_q == SEQ_DONE);
      if (accept) begin
        time_q  <= bus.i_Time;
        date_q  <= bus.i_Date;
        valid_q <= bus.i_Valid;
      end
    end
  end

  uart_tx u_uart_tx (
    .i_Clock        (i_Clock),
    .i_Reset        (i_Reset),
    .i_Clks_Per_Bit (bus.i_Clks_Per_Bit),
    .i_TX_DV        (tx_dv),
    .i_TX_Byte      (byte_mux),
    .o_TX_Serial    (tx_serial),
    .o_TX_Active    (tx_active),
    .o_TX_Done      (tx_done)
  );

  assign bus.o_TX_Serial = tx_serial;
  assign bus.o_Busy      = (state_q != SEQ_IDLE) || tx_active;
  assign bus.o_Done      = done_q;

endmodule

// File: tb/tb_nmea_rmc_tx.sv
// Directed bench for nmea_rmc_tx: decodes the UART line and compares sentences and timing.
module tb_nmea_rmc_tx;

  logic clk = 1'b0;
  logic rst = 1'b1;
  nmea_rmc_tx_if bus();

  nmea_rmc_tx dut (
    .i_Clock (clk),
    .i_Reset (rst),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errs   = 0;
  int cpb      = 4;
  int fe_cnt   = 0;
  int cyc      = 0;
  int t_acc    = 0;
  int dec_cnt  = 0;
  logic       dec_on = 1'b0;
  logic [7:0] dec_sh = '0;
  logic [7:0] rx_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Line decoder: samples mid-bit on the falling edge.
  always @(negedge clk) begin
    if (rst) begin
      dec_on <= 1'b0;
    end else if (!dec_on) begin
      if (bus.o_TX_Serial === 1'b0) begin
        dec_on  <= 1'b1;
        dec_cnt <= 1;
      end
    end else begin
      dec_cnt <= dec_cnt + 1;
      if ((dec_cnt % cpb) == (cpb / 2)) begin
        if ((dec_cnt / cpb) >= 1 && (dec_cnt / cpb) <= 8) begin
          dec_sh[(dec_cnt / cpb) - 1] <= bus.o_TX_Serial;
        end else if ((dec_cnt / cpb) == 9) begin
          if (bus.o_TX_Serial !== 1'b1) fe_cnt <= fe_cnt + 1;
          rx_q.push_back(dec_sh);
          dec_on <= 1'b0;
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic string rmc_model(input logic [23:0] t, input logic [23:0] d, input logic v);
    string hexd;
    string s;
    logic [7:0] cs;
    int n;
    hexd = "0123456789ABCDEF";
    s = "$GPRMC,";
    for (int i = 5; i >= 0; i--) begin
      n = int'(t[4*i +: 4]);
      s = {s, hexd.substr(n, n)};
    end
    if (v) s = {s, ",A,,,,,,,"};
    else   s = {s, ",V,,,,,,,"};
    for (int i = 5; i >= 0; i--) begin
      n = int'(d[4*i +: 4]);
      s = {s, hexd.substr(n, n)};
    end
    s = {s, ",,*"};
    cs = 8'h00;
    for (int i = 1; i <= 29; i++) cs = cs ^ s[i];
    n = int'(cs[7:4]);
    s = {s, hexd.substr(n, n)};
    n = int'(cs[3:0]);
    s = {s, hexd.substr(n, n), "\r\n"};
    return s;
  endfunction

  task automatic set_cpb(input int v);
    cpb = v;
    bus.i_Clks_Per_Bit = v[15:0];
  endtask

  task automatic do_start(input string tag);
    rx_q.delete();
    @(negedge clk);
    bus.i_Start = 1'b1;
    @(posedge clk);
    #1;
    bus.i_Start = 1'b0;
    t_acc = cyc;
    @(negedge clk);
    check({tag, "_busy_t1"}, 32'(bus.o_Busy), 32'd1);
    check({tag, "_line_t1"}, 32'(bus.o_TX_Serial), 32'd0);
  endtask

  task automatic wait_done(input string tag);
    while (bus.o_Done !== 1'b1 && (cyc - t_acc) < 350 * cpb + 200) @(negedge clk);
    check({tag, "_done_lat"}, 32'(cyc - t_acc), 32'(350 * cpb));
    check({tag, "_busy_at_done"}, 32'(bus.o_Busy), 32'd0);
  endtask

  task automatic wait_q(input string tag, input int n);
    int k = 0;
    while (rx_q.size() < n && k < 20 * cpb * n) begin
      @(negedge clk);
      k++;
    end
    check({tag, "_q_reached"}, 32'(rx_q.size() >= n), 32'd1);
  endtask

  task automatic compare_sentence(input string tag, input string exp);
    check({tag, "_len"}, 32'(rx_q.size()), 32'd35);
    for (int i = 0; i < 35; i++) begin
      check($sformatf("%s_b%0d", tag, i), 32'((i < rx_q.size()) ? rx_q[i] : 8'h00), 32'(exp[i]));
    end
  endtask

  initial begin
    bus.i_Start = 1'b0;
    bus.i_Time  = 24'h123456;
    bus.i_Date  = 24'h010224;
    bus.i_Valid = 1'b1;
    set_cpb(4);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_line", 32'(bus.o_TX_Serial), 32'd1);
    check("rst_busy", 32'(bus.o_Busy), 32'd0);
    check("rst_done", 32'(bus.o_Done), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Sentence with valid fix, hand-computed checksum 0x24.
    do_start("t1");
    wait_done("t1");
    compare_sentence("t1", "$GPRMC,123456,A,,,,,,,010224,,*24\r\n");
    @(negedge clk);
    check("t1_done_width", 32'(bus.o_Done), 32'd0);

    // Void status, checksum 0x33; a start coinciding with o_Done is dropped.
    bus.i_Valid = 1'b0;
    do_start("t2");
    wait_done("t2");
    bus.i_Start = 1'b1;
    @(posedge clk);
    #1;
    bus.i_Start = 1'b0;
    @(negedge clk);
    check("t2_start_on_done_busy", 32'(bus.o_Busy), 32'd0);
    compare_sentence("t2", "$GPRMC,123456,V,,,,,,,010224,,*33\r\n");

    // Restart request and input changes mid-sentence are ignored.
    bus.i_Valid = 1'b1;
    do_start("t3");
    wait_q("t3", 10);
    @(negedge clk);
    bus.i_Start = 1'b1;
    bus.i_Time  = 24'h654321;
    bus.i_Valid = 1'b0;
    @(negedge clk);
    bus.i_Start = 1'b0;
    wait_done("t3");
    compare_sentence("t3", rmc_model(24'h123456, 24'h010224, 1'b1));
    repeat (40) @(negedge clk);
    check("t3_no_second_busy", 32'(bus.o_Busy), 32'd0);
    check("t3_no_second_bytes", 32'(rx_q.size()), 32'd35);

    // Reset during byte 20's start bit, then a clean sentence.
    set_cpb(3);
    bus.i_Time  = 24'h235959;
    bus.i_Date  = 24'h311299;
    bus.i_Valid = 1'b1;
    do_start("t4");
    wait_q("t4", 20);
    begin
      int k = 0;
      while (bus.o_TX_Serial !== 1'b0 && k < 100) begin
        @(negedge clk);
        k++;
      end
      check("t4_start_bit_seen", 32'(bus.o_TX_Serial), 32'd0);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("t4_rst_line", 32'(bus.o_TX_Serial), 32'd1);
    check("t4_rst_busy", 32'(bus.o_Busy), 32'd0);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    check("t4_idle_after_rst", 32'(bus.o_Busy), 32'd0);
    do_start("t4b");
    wait_done("t4b");
    compare_sentence("t4b", rmc_model(24'h235959, 24'h311299, 1'b1));

    // Non-BCD time digit at the minimum bit period.
    set_cpb(2);
    bus.i_Time = 24'h1A0000;
    bus.i_Date = 24'h010224;
    do_start("t5");
    wait_done("t5");
    compare_sentence("t5", rmc_model(24'h1A0000, 24'h010224, 1'b1));
    check("t5_b7_digit", 32'((rx_q.size() > 7) ? rx_q[7] : 8'h00), 32'h31);
    check("t5_b8_digit", 32'((rx_q.size() > 8) ? rx_q[8] : 8'h00), 32'h41);

    check("framing_errors", 32'(fe_cnt), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
